irq_ctrl: RTL

- Programmable interrupt controller in front of the CP0 interrupt input.
- Collects up to N_SRC device interrupt lines (timers, UART, external pins) and latches them as pending, with per-source mask and per-source edge/level mode.
- Arbitrates by fixed priority and supports nested claim/EOI.
- Drives one registered request line, which the top level wires to HWInt[2]. The CPU accesses it through the bridge as a 4-word memory-mapped device.

---
 rtl/irq_ctrl_pkg.sv | 14 +
 rtl/irq_sync_edge.sv | 43 ++++
 rtl/irq_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - register word indices and bit positions for irq_ctrl
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        IRQC_MASK  = 2'd0,
        IRQC_MODE  = 2'd1,
        IRQC_PEND  = 2'd2,
        IRQC_CLAIM = 2'd3
    } irqc_reg_e;

    localparam int CLAIM_VALID_BIT = 31;
    localparam int CP0_HWINT_BIT   = 2;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - multi-flop synchronizer plus one-cycle delayed copy for edge detect
module irq_sync_edge #(
    parameter int W      = 6,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] sync_out,
    output logic [W-1:0] sync_prev
);

    logic [W-1:0] sync_q [STAGES];
    logic [W-1:0] sync_d [STAGES];
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;

    always_comb begin
        sync_d[0] = d_in;
        for (int k = 1; k < STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            prev_q <= prev_d;
        end
    end

    assign sync_out  = sync_q[STAGES-1];
    assign sync_prev = prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - fixed-priority nested interrupt controller driving one CP0 request line
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic             rd,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             irq_out
);

    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] isr_q, isr_d;
    logic             irq_out_q, irq_out_d;

    logic [N_SRC-1:0] s, s_prev, rise;
    logic [N_SRC-1:0] elig, claim_vec, w1c_vec, eoi_vec;
    logic [2:0]       winner;
    logic             any_elig, blocked, claim_fire, eoi_fire;
    logic             unused_wdata;

    irq_sync_edge #(.W(N_SRC), .STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (reset),
        .d_in      (irq_in),
        .sync_out  (s),
        .sync_prev (s_prev)
    );

    assign rise         = s & ~s_prev;
    assign unused_wdata = ^wdata;

    // Walk from highest priority down; the first in-service bit blocks it and everything below.
    always_comb begin
        elig    = '0;
        blocked = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            blocked = blocked | isr_q[i];
            elig[i] = pend_q[i] & mask_q[i] & ~blocked;
        end
        any_elig = |elig;
        winner   = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) winner = 3'(i);
        end
    end

    always_comb begin
        claim_fire = rd & (addr == IRQC_CLAIM) & any_elig;
        eoi_fire   = we & (addr == IRQC_CLAIM);
        w1c_vec    = (we && addr == IRQC_PEND) ? wdata[N_SRC-1:0] : '0;
        claim_vec  = '0;
        eoi_vec    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            claim_vec[i] = claim_fire & (winner == 3'(i));
            eoi_vec[i]   = eoi_fire & (wdata[2:0] == 3'(i));
        end

        mask_d = (we && addr == IRQC_MASK) ? wdata[N_SRC-1:0] : mask_q;
        mode_d = (we && addr == IRQC_MODE) ? wdata[N_SRC-1:0] : mode_q;
        isr_d  = (isr_q | claim_vec) & ~eoi_vec;
        // Edge sources: a fresh rising edge beats both W1C and claim clearing in the same cycle.
        for (int i = 0; i < N_SRC; i++) begin
            if (mode_q[i]) begin
                pend_d[i] = (pend_q[i] & ~w1c_vec[i] & ~claim_vec[i]) | rise[i];
            end else begin
                pend_d[i] = s[i];
            end
        end
        irq_out_d = any_elig;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q    <= '0;
            mode_q    <= '0;
            pend_q    <= '0;
            isr_q     <= '0;
            irq_out_q <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            isr_q     <= isr_d;
            irq_out_q <= irq_out_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (irqc_reg_e'(addr))
            IRQC_MASK:  rdata[N_SRC-1:0] = mask_q;
            IRQC_MODE:  rdata[N_SRC-1:0] = mode_q;
            IRQC_PEND:  rdata[N_SRC-1:0] = pend_q;
            IRQC_CLAIM: begin
                rdata[2:0]             = winner;
                rdata[CLAIM_VALID_BIT] = any_elig;
            end
            default:    rdata = '0;
        endcase
    end

    assign irq_out = irq_out_q;

endmodule
